board_ram_arbiter: RTL and testbench
====================================

Name: board_ram_arbiter

Overview:
- Shares one single-port synchronous board RAM (one KIND_W-bit cell per playfield square) between two requesters:
  - the VGA display pipeline, which reads one cell per pixel tick inside the playfield window with fixed latency and absolute priority;
  - the game logic, which issues cell writes, single reads, and a whole-board clear.
- Sits between the game engine and the display block; the display's tetris_x/tetris_y feed disp_x/disp_y, and disp_kind feeds the display's kind input.

Parameters:
- COLS, 10, playfield columns
- ROWS, 20, playfield rows
- KIND_W, 4, bits per cell
- ADDR_W, 8, RAM address width (must hold COLS*ROWS-1)
- FIFO_DEPTH, 4, game write queue entries (power of two)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- disp_en  in  1  display read request this cycle (pixel inside playfield)
- disp_x  in  5  display column
- disp_y  in  5  display row
- disp_kind  out  KIND_W  cell contents for the display, 2-cycle latency
- wr_valid  in  1  game write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_x  in  5  write column
- wr_y  in  5  write row
- wr_kind  in  KIND_W  write data
- rd_valid  in  1  game read request
- rd_ready  out  1  read accepted when rd_valid && rd_ready
- rd_x  in  5  read column
- rd_y  in  5  read row
- rd_resp_valid  out  1  one-cycle pulse; rd_kind valid
- rd_kind  out  KIND_W  read result
- clr_start  in  1  clear-board command pulse
- clr_busy  out  1  clear sweep in progress
- clr_done  out  1  one-cycle pulse after the last clear write
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  KIND_W  RAM write data
- ram_rdata  in  KIND_W  RAM read data, valid the cycle after the address is presented

Behaviour:
- Reset values:
  - all outputs 0, except wr_ready=1 and rd_ready=1;
  - FIFO empty, state IDLE;
  - RAM contents are not touched by reset.
- Address mapping: addr = y*COLS + x.
  - Coordinates with x>=COLS or y>=ROWS are out of range.
  - Out-of-range writes are accepted and dropped.
  - Out-of-range reads return 0.
- Port slot priority, evaluated every cycle:
  1. Display, when disp_en=1.
  2. CLEAR sweep.
  3. Head FIFO write.
  4. Granted game read.
  5. Idle: ram_we=0, ram_addr holds.
- Display path:
  - disp_kind is registered; it reflects the RAM cell at (disp_x,disp_y) sampled 2 clocks earlier.
  - If disp_en was 0 at that sample, or the coordinate was out of range, disp_kind=0.
  - Display is never stalled.
- Write FIFO:
  - Depth FIFO_DEPTH; a write is performed only in a free slot; entries drain in order.
  - wr_ready = !full && !clr_busy.
  - Simultaneous push and pop when full: not accepted, because wr_ready is already 0.
- Game read:
  - One outstanding read at most; rd_ready=0 from acceptance until rd_resp_valid.
  - The read is issued only when the FIFO is empty (read-after-write coherency), clr_busy=0, and the slot is free.
  - rd_resp_valid pulses 2 cycles after issue, with rd_kind registered.
- States: IDLE, CLEAR.
  - IDLE -> CLEAR on clr_start while clr_busy=0. On that edge:
    - FIFO is flushed (queued writes discarded);
    - a sweep counter is set to 0;
    - clr_busy=1 from the next cycle.
  - CLEAR: each free slot writes 0 to the counter address, then the counter increments. clr_start is ignored.
  - CLEAR -> IDLE after the write to address COLS*ROWS-1. clr_busy drops and clr_done pulses on the same edge.
  - A read already issued before clr_start completes normally. A read accepted but not yet issued waits until CLEAR ends and then returns 0.
- Write in the same cycle as clr_start: the push is accepted (wr_ready was 1) but then flushed.
- Asynchronous reset mid-clear or mid-read: immediate return to reset values; a partial clear is left as-is in RAM.

Test Plan:
- Reset, disp_en=1 with (3,5), RAM[53]=4'h6 -> disp_kind=6 exactly 2 clocks later; disp_en=0 -> disp_kind=0 two clocks later.
- Write (2,1,kind 5) with disp_en=0 -> ram_we=1, ram_addr=12, ram_wdata=5 within 1 cycle; then read (2,1) -> rd_resp_valid with rd_kind=5.
- disp_en held 1, push 5 writes -> wr_ready=0 after 4 accepts; no ram_we while disp_en=1; after disp_en=0 the 4 writes drain in order on consecutive cycles.
- Push 2 writes, then read the same cell before the drain -> read issued only after the FIFO is empty; returns the second write's data.
- clr_start with disp_en=0 -> clr_busy high exactly 200 cycles; addresses 0..199 written 0; clr_done pulse; wr_ready=0 throughout.
- Out-of-range write (10,0) -> accepted, no ram_we; read (0,20) -> rd_kind=0. Assert reset mid-clear at address 77 -> clr_busy=0, FIFO empty, wr_ready=1 on the next cycle.

Source files
------------

// File: rtl/board_ram_arbiter_if.sv
// board_ram_arbiter_if
//   Bundles every signal of the board RAM arbiter except clk/reset.
//   Groups:
//     display   : disp_en, disp_x, disp_y -> disp_kind (2-cycle latency)
//     game write: wr_valid/wr_ready handshake, wr_x, wr_y, wr_kind
//     game read : rd_valid/rd_ready handshake, rd_x, rd_y -> rd_resp_valid, rd_kind
//     clear     : clr_start -> clr_busy, clr_done
//     RAM port  : ram_addr, ram_we, ram_wdata -> ram_rdata (1-cycle read latency)
//   Modports:
//     slave  - the arbiter itself
//     master - the surrounding system (game engine, display, RAM)
interface board_ram_arbiter_if #(
    parameter int KIND_W = 4,
    parameter int ADDR_W = 8
);
    logic              disp_en;
    logic [4:0]        disp_x;
    logic [4:0]        disp_y;
    logic [KIND_W-1:0] disp_kind;

    logic              wr_valid;
    logic              wr_ready;
    logic [4:0]        wr_x;
    logic [4:0]        wr_y;
    logic [KIND_W-1:0] wr_kind;

    logic              rd_valid;
    logic              rd_ready;
    logic [4:0]        rd_x;
    logic [4:0]        rd_y;
    logic              rd_resp_valid;
    logic [KIND_W-1:0] rd_kind;

    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [KIND_W-1:0] ram_wdata;
    logic [KIND_W-1:0] ram_rdata;

    modport slave (
        input  disp_en, disp_x, disp_y,
        input  wr_valid, wr_x, wr_y, wr_kind,
        input  rd_valid, rd_x, rd_y,
        input  clr_start,
        input  ram_rdata,
        output disp_kind, wr_ready, rd_ready, rd_resp_valid, rd_kind,
        output clr_busy, clr_done,
        output ram_addr, ram_we, ram_wdata
    );

    modport master (
        output disp_en, disp_x, disp_y,
        output wr_valid, wr_x, wr_y, wr_kind,
        output rd_valid, rd_x, rd_y,
        output clr_start,
        output ram_rdata,
        input  disp_kind, wr_ready, rd_ready, rd_resp_valid, rd_kind,
        input  clr_busy, clr_done,
        input  ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter
//   Shares one single-port synchronous board RAM between the display
//   (absolute priority, fixed 2-cycle latency) and the game logic (queued
//   writes, single outstanding read, whole-board clear sweep).
//   Ports:
//     clk   - system clock
//     reset - asynchronous, active-high reset
//     bus   - board_ram_arbiter_if.slave (display, game write/read, clear, RAM)
//   The RAM address/we/wdata are driven combinationally from registered
//   state and the current display request so that a display read presented
//   in cycle N appears on disp_kind after the edge ending cycle N+1.
module board_ram_arbiter #(
    parameter int COLS       = 10,
    parameter int ROWS       = 20,
    parameter int KIND_W     = 4,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    board_ram_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

    typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;

    function automatic logic in_range(input logic [4:0] x, input logic [4:0] y);
        return (32'(x) < 32'(COLS)) && (32'(y) < 32'(ROWS));
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] x, input logic [4:0] y);
        return ADDR_W'(32'(y) * 32'(COLS) + 32'(x));
    endfunction

    // Control state
    state_t            state_reg;
    logic [ADDR_W-1:0] clr_cnt_reg;
    logic              clr_busy_reg;
    logic              clr_done_reg;
    logic [ADDR_W-1:0] last_addr_reg;

    // Write queue
    logic [PTR_W-1:0]  wptr_reg;
    logic [PTR_W-1:0]  rptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [KIND_W-1:0] fifo_kind [FIFO_DEPTH];

    // Read / display pipelines
    logic              rd_pend_reg;
    logic              rd_ok_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic              rd_ready_reg;
    logic              rd_v1_reg;
    logic              rd_ok1_reg;
    logic              rd_resp_valid_reg;
    logic [KIND_W-1:0] rd_kind_reg;
    logic              disp_v1_reg;
    logic [KIND_W-1:0] disp_kind_reg;

    // Combinational decisions
    logic              disp_ok;
    logic              wr_ready_c;
    logic              push;
    logic              push_keep;
    logic              clr_go;
    logic              rd_accept;
    logic              pop;
    logic              rd_issue;
    logic              clr_wr;
    logic [ADDR_W-1:0] addr_next;
    logic              we_next;
    logic [KIND_W-1:0] wdata_next;

    assign disp_ok    = in_range(bus.disp_x, bus.disp_y);
    assign wr_ready_c = (count_reg != CNT_W'(FIFO_DEPTH)) && !clr_busy_reg;
    assign push       = bus.wr_valid && wr_ready_c;
    // Out-of-range writes complete the handshake but never enter the queue.
    assign push_keep  = push && in_range(bus.wr_x, bus.wr_y);
    assign clr_go     = bus.clr_start && !clr_busy_reg;
    assign rd_accept  = bus.rd_valid && rd_ready_reg;

    // Single RAM slot, fixed priority: display, clear, queued write, read.
    always_comb begin
        addr_next  = last_addr_reg;
        we_next    = 1'b0;
        wdata_next = '0;
        pop        = 1'b0;
        rd_issue   = 1'b0;
        clr_wr     = 1'b0;
        if (bus.disp_en) begin
            if (disp_ok) begin
                addr_next = cell_addr(bus.disp_x, bus.disp_y);
            end
        end else if (state_reg == ST_CLEAR) begin
            clr_wr    = 1'b1;
            we_next   = 1'b1;
            addr_next = clr_cnt_reg;
        end else if (count_reg != '0) begin
            pop        = 1'b1;
            we_next    = 1'b1;
            addr_next  = fifo_addr[rptr_reg];
            wdata_next = fifo_kind[rptr_reg];
        end else if (rd_pend_reg) begin
            // Queue empty here, so the read sees every earlier write.
            rd_issue = 1'b1;
            if (rd_ok_reg) begin
                addr_next = rd_addr_reg;
            end
        end
    end

    // Queue storage: one register pair per entry, loaded when the write
    // pointer selects it. No reset needed; occupancy is tracked by count_reg.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
            logic [ADDR_W-1:0] addr_q;
            logic [KIND_W-1:0] kind_q;
            always_ff @(posedge clk) begin
                if (push_keep && (wptr_reg == PTR_W'(gi))) begin
                    addr_q <= cell_addr(bus.wr_x, bus.wr_y);
                    kind_q <= bus.wr_kind;
                end
            end
            assign fifo_addr[gi] = addr_q;
            assign fifo_kind[gi] = kind_q;
        end
    endgenerate

    // Clear FSM and queue pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            clr_cnt_reg   <= '0;
            clr_busy_reg  <= 1'b0;
            clr_done_reg  <= 1'b0;
            last_addr_reg <= '0;
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
        end else begin
            last_addr_reg <= addr_next;
            clr_done_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (clr_go) begin
                        // Flush wins over a push landing on the same edge.
                        state_reg    <= ST_CLEAR;
                        clr_busy_reg <= 1'b1;
                        clr_cnt_reg  <= '0;
                        wptr_reg     <= '0;
                        rptr_reg     <= '0;
                        count_reg    <= '0;
                    end else begin
                        if (push_keep) wptr_reg <= wptr_reg + 1'b1;
                        if (pop)       rptr_reg <= rptr_reg + 1'b1;
                        count_reg <= count_reg + CNT_W'(push_keep) - CNT_W'(pop);
                    end
                end
                ST_CLEAR: begin
                    if (clr_wr) begin
                        if (clr_cnt_reg == LAST_ADDR) begin
                            state_reg    <= ST_IDLE;
                            clr_busy_reg <= 1'b0;
                            clr_done_reg <= 1'b1;
                        end else begin
                            clr_cnt_reg <= clr_cnt_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Game read and display result pipelines
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_reg       <= 1'b0;
            rd_ok_reg         <= 1'b0;
            rd_addr_reg       <= '0;
            rd_ready_reg      <= 1'b1;
            rd_v1_reg         <= 1'b0;
            rd_ok1_reg        <= 1'b0;
            rd_resp_valid_reg <= 1'b0;
            rd_kind_reg       <= '0;
            disp_v1_reg       <= 1'b0;
            disp_kind_reg     <= '0;
        end else begin
            disp_v1_reg   <= bus.disp_en && disp_ok;
            disp_kind_reg <= disp_v1_reg ? bus.ram_rdata : '0;

            if (rd_accept) begin
                rd_pend_reg  <= 1'b1;
                rd_ready_reg <= 1'b0;
                rd_ok_reg    <= in_range(bus.rd_x, bus.rd_y);
                rd_addr_reg  <= cell_addr(bus.rd_x, bus.rd_y);
            end
            if (rd_issue) begin
                rd_pend_reg <= 1'b0;
            end
            rd_v1_reg         <= rd_issue;
            rd_ok1_reg        <= rd_issue && rd_ok_reg;
            rd_resp_valid_reg <= rd_v1_reg;
            if (rd_v1_reg) begin
                rd_kind_reg  <= rd_ok1_reg ? bus.ram_rdata : '0;
                rd_ready_reg <= 1'b1;
            end
        end
    end

    assign bus.disp_kind     = disp_kind_reg;
    assign bus.wr_ready      = wr_ready_c;
    assign bus.rd_ready      = rd_ready_reg;
    assign bus.rd_resp_valid = rd_resp_valid_reg;
    assign bus.rd_kind       = rd_kind_reg;
    assign bus.clr_busy      = clr_busy_reg;
    assign bus.clr_done      = clr_done_reg;
    assign bus.ram_addr      = addr_next;
    assign bus.ram_we        = we_next;
    assign bus.ram_wdata     = wdata_next;
endmodule

// File: tb/tb_board_ram_arbiter.sv
module tb_board_ram_arbiter;
    localparam int KW = 4;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    board_ram_arbiter_if #(.KIND_W(KW), .ADDR_W(AW)) bus();

    board_ram_arbiter #(
        .COLS(10), .ROWS(20), .KIND_W(KW), .ADDR_W(AW), .FIFO_DEPTH(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Board RAM model: single port, registered read, plus a bench-side poke port.
    logic [KW-1:0] mem [256];
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [KW-1:0] poke_data = '0;

    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok %s = %0d", tag, got);
        end
    endtask

    task automatic poke(input int a, input int d);
        poke_en   = 1'b1;
        poke_addr = AW'(a);
        poke_data = KW'(d);
        step();
        poke_en = 1'b0;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (!bus.rd_resp_valid && n < 20) begin
            step();
            n++;
        end
        if (!bus.rd_resp_valid) check("rd_resp_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, acc, we_seen, bad, wr_bad;
        bus.disp_en = 0; bus.disp_x = 0; bus.disp_y = 0;
        bus.wr_valid = 0; bus.wr_x = 0; bus.wr_y = 0; bus.wr_kind = 0;
        bus.rd_valid = 0; bus.rd_x = 0; bus.rd_y = 0;
        bus.clr_start = 0;

        // Preload under reset
        poke(53, 6);
        poke(200, 7);
        poke(1, 2);
        step();
        check("rst_wr_ready", int'(bus.wr_ready), 1);
        check("rst_rd_ready", int'(bus.rd_ready), 1);
        reset = 1'b0;
        #1;
        check("rst_disp_kind", int'(bus.disp_kind), 0);
        check("rst_clr_busy", int'(bus.clr_busy), 0);
        check("rst_ram_we", int'(bus.ram_we), 0);
        check("rst_rd_resp", int'(bus.rd_resp_valid), 0);

        // Display read latency
        bus.disp_en = 1; bus.disp_x = 3; bus.disp_y = 5;
        step();
        bus.disp_en = 0;
        check("disp_lat1", int'(bus.disp_kind), 0);
        step();
        check("disp_lat2", int'(bus.disp_kind), 6);
        step();
        check("disp_off", int'(bus.disp_kind), 0);

        // Single write then read back
        bus.wr_valid = 1; bus.wr_x = 2; bus.wr_y = 1; bus.wr_kind = 5;
        #1;
        check("wr1_ready", int'(bus.wr_ready), 1);
        step();
        bus.wr_valid = 0;
        #1;
        check("wr1_we", int'(bus.ram_we), 1);
        check("wr1_addr", int'(bus.ram_addr), 12);
        check("wr1_data", int'(bus.ram_wdata), 5);
        step();
        check("wr1_we_off", int'(bus.ram_we), 0);
        bus.rd_valid = 1; bus.rd_x = 2; bus.rd_y = 1;
        step();
        bus.rd_valid = 0;
        check("rd1_busy", int'(bus.rd_ready), 0);
        wait_resp(n);
        check("rd1_latency", n, 2);
        check("rd1_kind", int'(bus.rd_kind), 5);
        check("rd1_ready_back", int'(bus.rd_ready), 1);

        // Display outside the playfield: (12,0) would alias cell 12
        bus.disp_en = 1; bus.disp_x = 12; bus.disp_y = 0;
        step();
        bus.disp_en = 0;
        step();
        check("disp_oor", int'(bus.disp_kind), 0);

        // Queue fills while display owns the port, then drains in order
        bus.disp_en = 1; bus.disp_x = 0; bus.disp_y = 0;
        acc = 0; we_seen = 0;
        for (int i = 0; i < 5; i++) begin
            bus.wr_valid = 1; bus.wr_x = 5'(i); bus.wr_y = 2; bus.wr_kind = KW'(i + 1);
            #1;
            if (bus.wr_ready) acc++;
            if (bus.ram_we) we_seen++;
            step();
        end
        bus.wr_valid = 0;
        #1;
        if (bus.ram_we) we_seen++;
        check("fifo_accepts", acc, 4);
        check("fifo_full_ready", int'(bus.wr_ready), 0);
        check("we_during_disp", we_seen, 0);
        bus.disp_en = 0;
        #1;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("drain%0d_we", j), int'(bus.ram_we), 1);
            check($sformatf("drain%0d_addr", j), int'(bus.ram_addr), 20 + j);
            check($sformatf("drain%0d_data", j), int'(bus.ram_wdata), j + 1);
            step();
        end
        check("drain_done_we", int'(bus.ram_we), 0);
        check("drain_done_ready", int'(bus.wr_ready), 1);

        // Read waits behind queued writes to the same cell
        bus.disp_en = 1;
        bus.wr_valid = 1; bus.wr_x = 7; bus.wr_y = 3; bus.wr_kind = 9;
        step();
        bus.wr_kind = 10;
        step();
        bus.wr_valid = 0;
        bus.rd_valid = 1; bus.rd_x = 7; bus.rd_y = 3;
        #1;
        check("raw_rd_ready", int'(bus.rd_ready), 1);
        step();
        bus.rd_valid = 0;
        bus.disp_en = 0;
        #1;
        check("raw_w1_data", int'(bus.ram_we) * 16 + int'(bus.ram_wdata), 16 + 9);
        step();
        check("raw_w2_data", int'(bus.ram_we) * 16 + int'(bus.ram_wdata), 16 + 10);
        step();
        check("raw_issue_we", int'(bus.ram_we), 0);
        check("raw_issue_addr", int'(bus.ram_addr), 37);
        wait_resp(n);
        check("raw_latency", n, 2);
        check("raw_kind", int'(bus.rd_kind), 10);

        // Clear sweep; a push in the clr_start cycle is flushed
        bus.clr_start = 1;
        bus.wr_valid = 1; bus.wr_x = 1; bus.wr_y = 0; bus.wr_kind = 15;
        #1;
        check("clr_push_ready", int'(bus.wr_ready), 1);
        step();
        bus.clr_start = 0;
        bus.wr_valid = 0;
        check("clr_busy_start", int'(bus.clr_busy), 1);
        n = 0; bad = 0; wr_bad = 0;
        while (bus.clr_busy && n < 300) begin
            if (!(bus.ram_we && bus.ram_wdata == 0 && int'(bus.ram_addr) == n)) bad++;
            if (bus.wr_ready) wr_bad++;
            n++;
            step();
        end
        check("clr_cycles", n, 200);
        check("clr_seq_errors", bad, 0);
        check("clr_wr_ready_errors", wr_bad, 0);
        check("clr_done_pulse", int'(bus.clr_done), 1);
        step();
        check("clr_done_off", int'(bus.clr_done), 0);
        check("clr_mem53", int'(mem[53]), 0);
        check("clr_mem1_flushed", int'(mem[1]), 0);
        check("clr_mem199", int'(mem[199]), 0);
        check("clr_mem200_kept", int'(mem[200]), 7);

        // Out-of-range write and read
        bus.wr_valid = 1; bus.wr_x = 10; bus.wr_y = 0; bus.wr_kind = 3;
        #1;
        check("oor_wr_ready", int'(bus.wr_ready), 1);
        step();
        bus.wr_valid = 0;
        #1;
        check("oor_wr_we", int'(bus.ram_we), 0);
        bus.rd_valid = 1; bus.rd_x = 0; bus.rd_y = 20;
        step();
        bus.rd_valid = 0;
        wait_resp(n);
        check("oor_rd_latency", n, 2);
        check("oor_rd_kind", int'(bus.rd_kind), 0);

        // Reset in the middle of a clear
        poke(76, 9);
        poke(78, 9);
        bus.clr_start = 1;
        step();
        bus.clr_start = 0;
        n = 0;
        while (int'(bus.ram_addr) != 77 && n < 300) begin
            step();
            n++;
        end
        check("midclr_reached77", n, 77);
        reset = 1'b1;
        #1;
        check("midclr_busy", int'(bus.clr_busy), 0);
        check("midclr_wr_ready", int'(bus.wr_ready), 1);
        check("midclr_we", int'(bus.ram_we), 0);
        step();
        reset = 1'b0;
        #1;
        check("post_rst_busy", int'(bus.clr_busy), 0);
        check("post_rst_wr_ready", int'(bus.wr_ready), 1);
        step();
        check("post_rst_we", int'(bus.ram_we), 0);
        check("partial_mem76", int'(mem[76]), 0);
        check("partial_mem78", int'(mem[78]), 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
